// File: rtl/pc_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_source_ctrl
// Purpose  : Resolves branch/jump/jr/rte/exception PC sources and sequences
//            the EPC save plus exception-vector fetch.
// Revision : 1.0 - initial release
// ============================================================================
module pc_source_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       lt,
    input  logic       opcode_exc,
    input  logic       ovf_exc,
    input  logic       div0_exc,
    output logic [2:0] muxpcsource,
    output logic       pcWrite,
    output logic       epcWrite,
    output logic       memRead,
    output logic [1:0] excAddrSel,
    output logic       busy,
    output logic       done
);

    localparam int c_CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [c_CW-1:0] c_LOAD = (MEM_WAIT > 0) ? c_CW'(MEM_WAIT - 1) : '0;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_BLE   = 6'h06;
    localparam logic [5:0] c_OP_BGT   = 6'h07;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_RTE   = 6'h13;

    localparam logic [2:0] c_SRC_MEM   = 3'd0;
    localparam logic [2:0] c_SRC_ALU   = 3'd1;
    localparam logic [2:0] c_SRC_ALUO  = 3'd2;
    localparam logic [2:0] c_SRC_SHL2  = 3'd3;
    localparam logic [2:0] c_SRC_EPC   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESOLVE  = 3'd1,
        S_EXC_SAVE = 3'd2,
        S_EXC_WAIT = 3'd3,
        S_EXC_LOAD = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [5:0]        r_op;
    logic [5:0]        r_funct;
    logic              r_zero;
    logic              r_lt;
    logic [1:0]        r_exc_sel;
    logic [c_CW-1:0]   r_cnt;

    logic              w_accept;
    logic              w_any_exc;
    logic [1:0]        w_exc_sel;
    logic              w_taken;

    assign w_accept  = (r_state == S_IDLE) && req;
    assign w_any_exc = opcode_exc | ovf_exc | div0_exc;
    assign w_exc_sel = opcode_exc ? 2'd0 : (ovf_exc ? 2'd1 : 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= '0;
            r_funct   <= '0;
            r_zero    <= 1'b0;
            r_lt      <= 1'b0;
            r_exc_sel <= 2'd0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= op;
                r_funct   <= funct;
                r_zero    <= zero;
                r_lt      <= lt;
                r_exc_sel <= w_exc_sel;
            end
            if (r_state == S_EXC_SAVE) begin
                r_cnt <= c_LOAD;
            end else if ((r_state == S_EXC_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next = w_any_exc ? S_EXC_SAVE : S_RESOLVE;
                end
            end
            S_RESOLVE:  w_next = S_IDLE;
            S_EXC_SAVE: w_next = (MEM_WAIT == 0) ? S_EXC_LOAD : S_EXC_WAIT;
            S_EXC_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_EXC_LOAD;
                end
            end
            S_EXC_LOAD: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Branch condition is evaluated on the flags captured with the request.
    always_comb begin
        w_taken = 1'b0;
        case (r_op)
            c_OP_BEQ: w_taken = r_zero;
            c_OP_BNE: w_taken = ~r_zero;
            c_OP_BLE: w_taken = r_lt | r_zero;
            c_OP_BGT: w_taken = ~(r_lt | r_zero);
            default:  w_taken = 1'b0;
        endcase
    end

    always_comb begin
        muxpcsource = c_SRC_ALU;
        pcWrite     = 1'b0;
        epcWrite    = 1'b0;
        memRead     = 1'b0;
        excAddrSel  = 2'd0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_RESOLVE: begin
                done = 1'b1;
                case (r_op)
                    c_OP_BEQ, c_OP_BNE, c_OP_BLE, c_OP_BGT: begin
                        if (w_taken) begin
                            muxpcsource = c_SRC_ALUO;
                            pcWrite     = 1'b1;
                        end
                    end
                    c_OP_J, c_OP_JAL: begin
                        muxpcsource = c_SRC_SHL2;
                        pcWrite     = 1'b1;
                    end
                    c_OP_RTYPE: begin
                        if (r_funct == c_FN_JR) begin
                            muxpcsource = c_SRC_ALU;
                            pcWrite     = 1'b1;
                        end else if (r_funct == c_FN_RTE) begin
                            muxpcsource = c_SRC_EPC;
                            pcWrite     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_EXC_SAVE: begin
                epcWrite   = 1'b1;
                memRead    = 1'b1;
                excAddrSel = r_exc_sel;
            end
            S_EXC_WAIT: begin
                excAddrSel = r_exc_sel;
            end
            S_EXC_LOAD: begin
                excAddrSel  = r_exc_sel;
                muxpcsource = c_SRC_MEM;
                pcWrite     = 1'b1;
                done        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_source_ctrl
// Purpose  : Directed vector bench for pc_source_ctrl (MEM_WAIT = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_source_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       lt;
    logic       opcode_exc;
    logic       ovf_exc;
    logic       div0_exc;
    logic [2:0] muxpcsource;
    logic       pcWrite;
    logic       epcWrite;
    logic       memRead;
    logic [1:0] excAddrSel;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    pc_source_ctrl #(.MEM_WAIT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .lt         (lt),
        .opcode_exc (opcode_exc),
        .ovf_exc    (ovf_exc),
        .div0_exc   (div0_exc),
        .muxpcsource(muxpcsource),
        .pcWrite    (pcWrite),
        .epcWrite   (epcWrite),
        .memRead    (memRead),
        .excAddrSel (excAddrSel),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       lt;
        logic [2:0] exp_mux;
        logic       exp_pcw;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic [5:0] o, input logic [5:0] f, input logic z, input logic l,
                             input logic oe, input logic ve, input logic de);
        op = o; funct = f; zero = z; lt = l;
        opcode_exc = oe; ovf_exc = ve; div0_exc = de;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0; opcode_exc = 1'b0; ovf_exc = 1'b0; div0_exc = 1'b0;
    endtask

    task automatic chk_idle_outs(input string nm, input logic [1:0] sel);
        chk({nm, "_mux"}, {5'd0, muxpcsource}, 8'd1);
        chk({nm, "_writes"}, {5'd0, pcWrite, epcWrite, memRead}, 8'd0);
        chk({nm, "_done"}, {7'd0, done}, 8'd0);
        chk({nm, "_sel"}, {6'd0, excAddrSel}, {6'd0, sel});
    endtask

    // Exception request: check EXC_SAVE, then wait (bounded) for the load cycle.
    task automatic exc_run(input string nm, input logic oe, input logic ve, input logic de,
                           input logic [1:0] sel);
        int n;
        drive_req(6'h00, 6'h20, 1'b0, 1'b0, oe, ve, de);
        chk({nm, "_save_epcw"}, {7'd0, epcWrite}, 8'd1);
        chk({nm, "_save_sel"}, {6'd0, excAddrSel}, {6'd0, sel});
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_load_cycles"}, n[7:0], 8'd3);
        chk({nm, "_load_mux"}, {5'd0, muxpcsource}, 8'd0);
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        int nbad;
        vecs[0]  = '{6'h04, 6'h00, 1'b1, 1'b0, 3'd2, 1'b1}; // beq taken
        vecs[1]  = '{6'h05, 6'h00, 1'b1, 1'b0, 3'd1, 1'b0}; // bne not taken
        vecs[2]  = '{6'h06, 6'h00, 1'b1, 1'b0, 3'd2, 1'b1}; // ble taken on zero
        vecs[3]  = '{6'h07, 6'h00, 1'b1, 1'b0, 3'd1, 1'b0}; // bgt not taken
        vecs[4]  = '{6'h02, 6'h00, 1'b0, 1'b0, 3'd3, 1'b1}; // j
        vecs[5]  = '{6'h00, 6'h08, 1'b0, 1'b0, 3'd1, 1'b1}; // jr
        vecs[6]  = '{6'h00, 6'h13, 1'b0, 1'b0, 3'd4, 1'b1}; // rte
        vecs[7]  = '{6'h03, 6'h00, 1'b1, 1'b1, 3'd3, 1'b1}; // jal
        vecs[8]  = '{6'h00, 6'h20, 1'b0, 1'b0, 3'd1, 1'b0}; // add: done only
        vecs[9]  = '{6'h23, 6'h00, 1'b1, 1'b0, 3'd1, 1'b0}; // lw: done only
        vecs[10] = '{6'h04, 6'h00, 1'b0, 1'b1, 3'd1, 1'b0}; // beq not taken
        vecs[11] = '{6'h07, 6'h00, 1'b0, 1'b0, 3'd2, 1'b1}; // bgt taken
        vecs[12] = '{6'h06, 6'h00, 1'b0, 1'b1, 3'd2, 1'b1}; // ble taken on lt

        reset = 1'b1; req = 1'b0; op = '0; funct = '0; zero = 1'b0; lt = 1'b0;
        opcode_exc = 1'b0; ovf_exc = 1'b0; div0_exc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk_idle_outs("rst", 2'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            drive_req(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].lt, 1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d_mux", i), {5'd0, muxpcsource}, {5'd0, vecs[i].exp_mux});
            chk($sformatf("v%0d_pcw", i), {7'd0, pcWrite}, {7'd0, vecs[i].exp_pcw});
            chk($sformatf("v%0d_done", i), {7'd0, done}, 8'd1);
            chk($sformatf("v%0d_busy", i), {7'd0, busy}, 8'd1);
            @(negedge clk);
            chk($sformatf("v%0d_after", i), {6'd0, done, pcWrite}, 8'd0);
        end

        // ovf + div0 together: ovf wins, second req during EXC_WAIT ignored
        drive_req(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("exc_c1_epcw_mem", {6'd0, epcWrite, memRead}, 8'd3);
        chk("exc_c1_sel", {6'd0, excAddrSel}, 8'd1);
        chk("exc_c1_pcw", {7'd0, pcWrite}, 8'd0);
        req = 1'b1; op = 6'h02;
        @(negedge clk);
        req = 1'b0;
        chk_idle_outs("exc_c2", 2'd1);
        chk("exc_c2_busy", {7'd0, busy}, 8'd1);
        @(negedge clk);
        chk_idle_outs("exc_c3", 2'd1);
        @(negedge clk);
        chk("exc_c4_mux", {5'd0, muxpcsource}, 8'd0);
        chk("exc_c4_pcw_done", {6'd0, pcWrite, done}, 8'd3);
        chk("exc_c4_epcw", {7'd0, epcWrite}, 8'd0);
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("exc_extra_done", ndone[7:0], 8'd0);
        chk("exc_end_busy", {7'd0, busy}, 8'd0);

        exc_run("exc_opc", 1'b1, 1'b1, 1'b1, 2'd0);
        exc_run("exc_div0", 1'b0, 1'b0, 1'b1, 2'd2);

        // reset during EXC_WAIT
        drive_req(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rstw_pre_busy", {7'd0, busy}, 8'd1);
        reset = 1'b1;
        #1;
        chk("rstw_busy", {7'd0, busy}, 8'd0);
        chk("rstw_mux", {5'd0, muxpcsource}, 8'd1);
        chk("rstw_sel", {6'd0, excAddrSel}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        nbad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pcWrite || epcWrite || done) nbad++;
        end
        chk("rstw_no_write", nbad[7:0], 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_source_ctrl.md
# pc_source_ctrl

Control-flow resolver that drives the select and write-enable on the CPU's PC source multiplexer. After decode, the main control unit issues one request per instruction. The block then resolves branch, jump, jr, rte and exception targets into a `muxpcsource` code and a one-cycle `pcWrite` pulse. For exceptions it also sequences the EPC save and the exception-vector memory load.

## Interface
Parameters:
- `MEM_WAIT`, default 2: memory read latency in cycles between vector address issue and valid `LSControlOut`.

Ports:
- `clk`, input, 1: system clock. Rising-edge active.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, 1: single-cycle request. Sampled only in IDLE.
- `op`, input, 6: instruction opcode. Captured with `req`.
- `funct`, input, 6: R-type funct field. Captured with `req`.
- `zero`, input, 1: ALU zero flag (rs − rt). Captured with `req`.
- `lt`, input, 1: ALU less-than flag (rs < rt, signed). Captured with `req`.
- `opcode_exc`, input, 1: invalid opcode detected. Captured with `req`.
- `ovf_exc`, input, 1: arithmetic overflow. Captured with `req`.
- `div0_exc`, input, 1: divide by zero. Captured with `req`.
- `muxpcsource`, output, 3: PC mux select. 0=LSControlOut, 1=aluResult, 2=aluOutOut, 3=shiftLeft2Out, 4=epcOut.
- `pcWrite`, output, 1: PC load enable.
- `epcWrite`, output, 1: EPC load enable.
- `memRead`, output, 1: vector fetch read strobe.
- `excAddrSel`, output, 2: vector select. 0→byte 253, 1→254, 2→255.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, RESOLVE, EXC_SAVE, EXC_WAIT, EXC_LOAD. All outputs are Moore, decoded from state plus captured registers.
- IDLE: a `req` captures all inputs.
  - If any captured exception flag is set, go to EXC_SAVE.
  - Otherwise go to RESOLVE.
- Exception priority: `opcode_exc` > `ovf_exc` > `div0_exc`. These give `excAddrSel` = 0 / 1 / 2 respectively.
- RESOLVE lasts 1 cycle. `done`=1. The captured `op` and `funct` select the action:
  - `op`=0x04 beq: taken if `zero`.
  - `op`=0x05 bne: taken if !`zero`.
  - `op`=0x06 ble: taken if `lt`|`zero`.
  - `op`=0x07 bgt: taken if !(`lt`|`zero`).
  - Taken branch: `muxpcsource`=2, `pcWrite`=1. Not taken: `pcWrite`=0, `muxpcsource`=1.
  - `op`=0x02 j or 0x03 jal: `muxpcsource`=3, `pcWrite`=1.
  - `op`=0x00 with `funct`=0x08 (jr): `muxpcsource`=1, `pcWrite`=1.
  - `op`=0x00 with `funct`=0x13 (rte): `muxpcsource`=4, `pcWrite`=1.
  - Any other instruction: `pcWrite`=0, `done` only.
  - Next state is IDLE.
- EXC_SAVE lasts 1 cycle. `epcWrite`=1 and `memRead`=1. `excAddrSel` takes its vector value and holds it through EXC_LOAD. Next state is EXC_WAIT.
- EXC_WAIT lasts `MEM_WAIT` cycles, counted by an internal counter loaded with `MEM_WAIT`−1. If `MEM_WAIT`=0, skip straight to EXC_LOAD.
- EXC_LOAD lasts 1 cycle. `muxpcsource`=0, `pcWrite`=1, `done`=1. Next state is IDLE.
- `req` while `busy`: ignored and not queued.
- Outputs outside the write cycles:
  - `muxpcsource`=1.
  - `pcWrite`, `epcWrite`, `memRead` and `done` are 0.
  - `excAddrSel`=0.

## Timing
- Reset values: state IDLE, `muxpcsource`=1, `excAddrSel`=0, counter 0. Every other output is 0.
- Reset asserted mid-operation: outputs return to their reset values immediately. No `pcWrite`, `epcWrite` or `done` follows reset release.
- Non-exception latency: a `req` sampled at edge N puts the result in RESOLVE during cycle N+1. `done` and `pcWrite` are high for that cycle only.
- Exception latency:
  - EXC_SAVE is cycle N+1.
  - EXC_WAIT covers cycles N+2 through N+1+`MEM_WAIT`.
  - EXC_LOAD is cycle N+2+`MEM_WAIT`.
  - Total is `MEM_WAIT`+2 cycles.
- `pcWrite` and `epcWrite` are never high in the same cycle.
- A back-to-back `req` is accepted in the cycle after `done`, because the block is in IDLE by then.

## Test plan
- beq with `zero`=1, then bne with `zero`=1:
  - beq: `muxpcsource`=2 with `pcWrite`=1 and `done`=1 one cycle after `req`.
  - bne: `pcWrite`=0, `muxpcsource`=1, `done`=1.
- ble with `lt`=0 and `zero`=1: taken, `muxpcsource`=2. Then bgt with the same flags: not taken.
- j, then jr (`op`=0, `funct`=0x08), then rte (`funct`=0x13): `muxpcsource` = 3, then 1, then 4, each with a 1-cycle `pcWrite`.
- `ovf_exc`=1 and `div0_exc`=1 together, `MEM_WAIT`=2:
  - Cycle +1: `epcWrite`=1, `memRead`=1, `excAddrSel`=1.
  - Cycles +2 and +3: idle outputs.
  - Cycle +4: `muxpcsource`=0, `pcWrite`=1, `done`=1.
- Second `req` pulsed during EXC_WAIT: ignored, with exactly one `done`.
- `reset` asserted in EXC_WAIT: `busy`=0 and `muxpcsource`=1 at once, and no `pcWrite` follows.
